// File: rtl/memShare_config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memShare_config_pkg
//  Description : Shared configuration for the message-pass read-port
//                scheduler: default widths/counts and the scheduler FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package memShare_config_pkg;

    // Default number of requesters sharing the message-pass read port
    localparam int c_DEF_RQST_NUM        = 4;
    // Default width of the beats-minus-one burst-length field
    localparam int c_DEF_LEN_WIDTH       = 4;
    // Message-pass address map: number of rebase base addresses and
    // width of the read offset within one base window
    localparam int MSGPASS_BASEADDR_NUM  = 8;
    localparam int MSGPASS_RD_ADDR_WIDTH = 8;

    // Scheduler state: waiting for a request / issuing the beats of a burst
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_e;

endpackage : memShare_config_pkg
`default_nettype wire

// File: rtl/memshare_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memshare_rr_arbiter
//  Description : Combinational round-robin arbiter. The search for a
//                requester starts at i_ptr and wraps around; the first
//                active request found wins.
//  Ports       : i_req   [RQST_NUM]  request vector
//                i_ptr   [ID_W]      first index to consider
//                o_grant [RQST_NUM]  one-hot grant (all-zero if no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module memshare_rr_arbiter #(
    parameter int RQST_NUM = 4,
    parameter int ID_W     = $clog2(RQST_NUM)
) (
    input  logic [RQST_NUM-1:0] i_req,
    input  logic [ID_W-1:0]     i_ptr,
    output logic [RQST_NUM-1:0] o_grant
);

    logic [RQST_NUM-1:0] w_grant;
    logic                w_found;
    logic [ID_W-1:0]     w_idx;
    int                  w_sum;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = 0;
        for (int i = 0; i < RQST_NUM; i++) begin
            // Rotate the candidate index by the pointer, wrapping at RQST_NUM
            // so non-power-of-two requester counts also work.
            w_sum = int'(i_ptr) + i;
            if (w_sum >= RQST_NUM) begin
                w_sum = w_sum - RQST_NUM;
            end
            w_idx = ID_W'(w_sum);
            if (!w_found && i_req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_grant = w_grant;

endmodule : memshare_rr_arbiter
`default_nettype wire

// File: rtl/memshare_rqst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : memshare_rqst_sched
//  Description : Shares the message-pass read port between RQST_NUM
//                requesters. A round-robin grant is made in IDLE, then the
//                captured burst (len+1 beats from a start offset) is issued
//                beat by beat, honouring a downstream stall. The beat owner
//                is reported one cycle later to line up with the rebase
//                block's register stage.
//  Ports       : sys_clk, rst (sync, active-high)
//                rqst_valid_i / rqst_ready_o   per-requester handshake
//                rqst_sel_i / rqst_ofst_i / rqst_len_i  packed burst params
//                stall_i                       downstream hold
//                baseAddr_sel_o, rd_ofst_o, rd_en_o     beat issue
//                rsp_valid_o, rsp_id_o         delayed beat owner
//                busy_o                        burst in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module memshare_rqst_sched
    import memShare_config_pkg::*;
#(
    parameter int RQST_NUM   = c_DEF_RQST_NUM,
    parameter int SEL_WIDTH  = $clog2(MSGPASS_BASEADDR_NUM),
    parameter int OFST_WIDTH = MSGPASS_RD_ADDR_WIDTH,
    parameter int LEN_WIDTH  = c_DEF_LEN_WIDTH
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic [RQST_NUM-1:0]            rqst_valid_i,
    output logic [RQST_NUM-1:0]            rqst_ready_o,
    input  logic [RQST_NUM*SEL_WIDTH-1:0]  rqst_sel_i,
    input  logic [RQST_NUM*OFST_WIDTH-1:0] rqst_ofst_i,
    input  logic [RQST_NUM*LEN_WIDTH-1:0]  rqst_len_i,
    input  logic                           stall_i,
    output logic [SEL_WIDTH-1:0]           baseAddr_sel_o,
    output logic [OFST_WIDTH-1:0]          rd_ofst_o,
    output logic                           rd_en_o,
    output logic                           rsp_valid_o,
    output logic [$clog2(RQST_NUM)-1:0]    rsp_id_o,
    output logic                           busy_o
);

    localparam int ID_W = $clog2(RQST_NUM);

    sched_state_e          r_state_q,     w_state_d;
    logic [ID_W-1:0]       r_ptr_q,       w_ptr_d;
    logic [ID_W-1:0]       r_id_q,        w_id_d;
    logic [SEL_WIDTH-1:0]  r_sel_q,       w_sel_d;
    logic [OFST_WIDTH-1:0] r_ofst_q,      w_ofst_d;
    logic [LEN_WIDTH-1:0]  r_cnt_q,       w_cnt_d;
    logic [SEL_WIDTH-1:0]  r_last_sel_q,  w_last_sel_d;
    logic [OFST_WIDTH-1:0] r_last_ofst_q, w_last_ofst_d;
    logic                  r_rsp_valid_q, w_rsp_valid_d;
    logic [ID_W-1:0]       r_rsp_id_q,    w_rsp_id_d;

    logic [RQST_NUM-1:0]   w_grant;
    logic [ID_W-1:0]       w_win_idx;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic                  w_beat;

    memshare_rr_arbiter #(
        .RQST_NUM (RQST_NUM),
        .ID_W     (ID_W)
    ) u_arb (
        .i_req   (rqst_valid_i),
        .i_ptr   (r_ptr_q),
        .o_grant (w_grant)
    );

    // One-hot grant to index
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < RQST_NUM; i++) begin
            if (w_grant[i]) begin
                w_win_idx = ID_W'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_win_idx == ID_W'(RQST_NUM - 1)) ? '0 : w_win_idx + ID_W'(1);

    // A beat issues on every unstalled BURST cycle; reset suppresses it
    // combinationally so nothing leaks out while rst is high.
    assign w_beat = (r_state_q == ST_BURST) && !stall_i && !rst;

    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_id_d        = r_id_q;
        w_sel_d       = r_sel_q;
        w_ofst_d      = r_ofst_q;
        w_cnt_d       = r_cnt_q;
        w_last_sel_d  = r_last_sel_q;
        w_last_ofst_d = r_last_ofst_q;
        w_rsp_valid_d = w_beat;
        w_rsp_id_d    = r_id_q;
        case (r_state_q)
            ST_IDLE: begin
                if (|rqst_valid_i) begin
                    w_state_d = ST_BURST;
                    w_id_d    = w_win_idx;
                    w_ptr_d   = w_ptr_nxt;
                    w_sel_d   = rqst_sel_i[int'(w_win_idx)*SEL_WIDTH +: SEL_WIDTH];
                    w_ofst_d  = rqst_ofst_i[int'(w_win_idx)*OFST_WIDTH +: OFST_WIDTH];
                    w_cnt_d   = rqst_len_i[int'(w_win_idx)*LEN_WIDTH +: LEN_WIDTH];
                end
            end
            ST_BURST: begin
                if (w_beat) begin
                    // Remember what went out so the outputs can hold it
                    // through stalls and idle cycles.
                    w_last_sel_d  = r_sel_q;
                    w_last_ofst_d = r_ofst_q;
                    w_ofst_d      = r_ofst_q + OFST_WIDTH'(1);
                    if (r_cnt_q == '0) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q - LEN_WIDTH'(1);
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_ptr_q       <= '0;
            r_id_q        <= '0;
            r_sel_q       <= '0;
            r_ofst_q      <= '0;
            r_cnt_q       <= '0;
            r_last_sel_q  <= '0;
            r_last_ofst_q <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_id_q    <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_id_q        <= w_id_d;
            r_sel_q       <= w_sel_d;
            r_ofst_q      <= w_ofst_d;
            r_cnt_q       <= w_cnt_d;
            r_last_sel_q  <= w_last_sel_d;
            r_last_ofst_q <= w_last_ofst_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_id_q    <= w_rsp_id_d;
        end
    end

    assign rqst_ready_o   = ((r_state_q == ST_IDLE) && !rst) ? w_grant : '0;
    assign rd_en_o        = w_beat;
    assign baseAddr_sel_o = w_beat ? r_sel_q  : r_last_sel_q;
    assign rd_ofst_o      = w_beat ? r_ofst_q : r_last_ofst_q;
    assign rsp_valid_o    = r_rsp_valid_q && !rst;
    assign rsp_id_o       = r_rsp_id_q;
    assign busy_o         = (r_state_q == ST_BURST);

endmodule : memshare_rqst_sched
`default_nettype wire

// File: doc/memshare_rqst_sched.md
MEMSHARE_RQST_SCHED -- requirements
Module: memshare_rqst_sched

Interface
REQ-001 SHALL have parameter RQST_NUM, default 4, meaning the number of requesters sharing the message-pass read port.
REQ-002 SHALL have parameter SEL_WIDTH, default $clog2(MSGPASS_BASEADDR_NUM), meaning the base-select width.
REQ-003 SHALL have parameter OFST_WIDTH, default MSGPASS_RD_ADDR_WIDTH, meaning the read-offset width.
REQ-004 SHALL have parameter LEN_WIDTH, default 4, meaning the burst-length field width.
REQ-005 SHALL have ports: sys_clk  in  1  sole clock; rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: rqst_valid_i  in  RQST_NUM  per-requester request; rqst_ready_o  out  RQST_NUM  one-hot accept.
REQ-007 SHALL have ports: rqst_sel_i  in  RQST_NUM*SEL_WIDTH  packed base select; rqst_ofst_i  in  RQST_NUM*OFST_WIDTH  packed start offset; rqst_len_i  in  RQST_NUM*LEN_WIDTH  packed beats-minus-one.
REQ-008 SHALL have ports: stall_i  in  1  downstream hold; baseAddr_sel_o  out  SEL_WIDTH  to rebase block; rd_ofst_o  out  OFST_WIDTH  beat offset; rd_en_o  out  1  beat issue.
REQ-009 SHALL have ports: rsp_valid_o  out  1  data valid at rebase output; rsp_id_o  out  $clog2(RQST_NUM)  owner of that beat; busy_o  out  1  burst in progress.

Function
REQ-010 SHALL implement FSM states IDLE and BURST.
REQ-011 In IDLE, if any rqst_valid_i is high, SHALL grant one requester by round-robin, starting the search at the index after the last granted one (index 0 after reset).
REQ-012 The grant SHALL assert rqst_ready_o[winner] for exactly one cycle, combinationally in the IDLE cycle, and capture its sel, offset and len; the FSM then enters BURST.
REQ-013 In BURST, with stall_i low, SHALL assert rd_en_o with baseAddr_sel_o = captured sel and rd_ofst_o = current offset, then increment the offset modulo 2^OFST_WIDTH and decrement the beat counter.
REQ-014 With stall_i high in BURST, SHALL deassert rd_en_o and hold the offset, counter and selection unchanged.
REQ-015 A burst SHALL issue exactly len+1 beats; after the last beat the FSM SHALL return to IDLE, leaving one idle cycle before the next grant.
REQ-016 rqst_ready_o SHALL be all-zero in BURST; requests arriving then SHALL wait.
REQ-017 The offset SHALL wrap from 2^OFST_WIDTH-1 to 0 without affecting the beat count.
REQ-018 rsp_valid_o and rsp_id_o SHALL equal rd_en_o and the grant index delayed by exactly one cycle, matching the one-register latency of the rebase block.
REQ-019 baseAddr_sel_o and rd_ofst_o SHALL hold their last values while rd_en_o is low.
REQ-020 busy_o SHALL be high exactly while the FSM is in BURST.

Reset
REQ-021 rst high at a clock edge SHALL force IDLE, the round-robin pointer to 0, and all outputs to 0 at the next cycle, aborting any burst in progress.
REQ-022 While rst is high, SHALL assert no rqst_ready_o, rd_en_o or rsp_valid_o, including the delayed rsp_valid_o of a beat issued just before reset.

Structure
REQ-023 The FSM state enum, LEN_WIDTH and RQST_NUM defaults SHALL reside in memShare_config_pkg.
REQ-024 The round-robin grant logic SHALL be a sub-module named memshare_rr_arbiter (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-025 Requester 2 only, sel=3, ofst=10, len=3 -> ready[2] one cycle; rd_en for 4 cycles with offsets 10,11,12,13 and sel=3; rsp_valid with id=2 one cycle later each.
REQ-026 All four requesters valid continuously, len=0 -> grants in order 0,1,2,3,0, one beat each, with one idle cycle between bursts.
REQ-027 ofst=2^OFST_WIDTH-2, len=3 -> offsets max-1, max, 0, 1.
REQ-028 stall_i high for 2 cycles during beat 2 of a len=3 burst -> rd_en low for 2 cycles, offsets continue without skipping, 4 beats total.
REQ-029 rst asserted during beat 1 of a len=7 burst -> next cycle IDLE, all outputs 0, pointer 0; a subsequent request from requester 1 is granted normally.
REQ-030 Requester 0 deasserts valid while requester 3 is pending -> pointer skips to 3 with no lost cycle beyond the IDLE cycle.
